// File: rtl/restoring_divider_pkg.sv
// Shared types and defaults for the restoring divider.
// The optional divide-by-zero detector is enabled with DIV_ZERO_DETECT_EN.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        StartState,
        LoadDivisorState,
        BeginCycleState,
        ShiftState,
        SubState,
        HaltState
    } div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Front-end bus between the switch/button panel and the divider.
// DivByZero exists only when DIV_ZERO_DETECT_EN is defined.
interface restoring_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
);
    logic             Run;
    logic             ClearR_LoadD;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
`ifdef DIV_ZERO_DETECT_EN
    logic             DivByZero;
`endif

    modport master (
        output Run,
        output ClearR_LoadD,
        output Din,
        input  Quotient,
        input  Remainder,
        input  Busy,
`ifdef DIV_ZERO_DETECT_EN
        input  DivByZero,
`endif
        input  Done
    );

    modport slave (
        input  Run,
        input  ClearR_LoadD,
        input  Din,
        output Quotient,
        output Remainder,
        output Busy,
`ifdef DIV_ZERO_DETECT_EN
        output DivByZero,
`endif
        output Done
    );

endinterface

// File: rtl/restoring_divider_control.sv
// Control FSM and shift counter for the restoring divider.
// With DIV_ZERO_DETECT_EN a zero divisor short-circuits straight to Halt.
module div_control
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearR_LoadD,
`ifdef DIV_ZERO_DETECT_EN
    input  logic d_is_zero,
    output logic div_zero_hit,
    output logic DivByZero,
`endif
    output logic load_d,
    output logic clear_rq,
    output logic load_q,
    output logic shift_en,
    output logic sub_en,
    output logic last,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t      state;
    div_state_t      next_state;
    logic [CW-1:0]   count;

    assign last = (count == CW'(WIDTH));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= StartState;
            count <= '0;
        end else begin
            state <= next_state;
            if (state == BeginCycleState) begin
                count <= '0;
            end else if (state == ShiftState) begin
                count <= count + 1'b1;
            end
        end
    end

    // Run has priority over ClearR_LoadD when both are pressed in Start.
    always_comb begin
        next_state = state;
        case (state)
            StartState: begin
                if (Run) begin
                    next_state = BeginCycleState;
                end else if (ClearR_LoadD) begin
                    next_state = LoadDivisorState;
                end
            end
            LoadDivisorState: begin
                if (!ClearR_LoadD) begin
                    next_state = StartState;
                end
            end
            BeginCycleState: begin
`ifdef DIV_ZERO_DETECT_EN
                if (d_is_zero) begin
                    next_state = HaltState;
                end else begin
                    next_state = ShiftState;
                end
`else
                next_state = ShiftState;
`endif
            end
            ShiftState: next_state = SubState;
            SubState: begin
                if (last) begin
                    next_state = HaltState;
                end else begin
                    next_state = ShiftState;
                end
            end
            HaltState: begin
                if (!Run) begin
                    next_state = StartState;
                end
            end
            default: next_state = StartState;
        endcase
    end

    always_comb begin
        load_d   = 1'b0;
        clear_rq = 1'b0;
        load_q   = 1'b0;
        shift_en = 1'b0;
        sub_en   = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_hit = 1'b0;
`endif
        case (state)
            LoadDivisorState: begin
                load_d   = 1'b1;
                clear_rq = 1'b1;
            end
            BeginCycleState: begin
                Busy = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                div_zero_hit = d_is_zero;
                load_q       = !d_is_zero;
`else
                load_q = 1'b1;
`endif
            end
            ShiftState: begin
                Busy     = 1'b1;
                shift_en = 1'b1;
            end
            SubState: begin
                Busy   = 1'b1;
                sub_en = 1'b1;
            end
            HaltState: Done = 1'b1;
            default: ;
        endcase
    end

`ifdef DIV_ZERO_DETECT_EN
    // The flag lives exactly as long as the Halt it caused.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DivByZero <= 1'b0;
        end else if (div_zero_hit) begin
            DivByZero <= 1'b1;
        end else if (state == HaltState && !Run) begin
            DivByZero <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: R/Q/D datapath driven by div_control.
// Optional divide-by-zero detection is compiled in with DIV_ZERO_DETECT_EN.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    restoring_divider_if.slave bus
);

    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   diff;

    logic load_d;
    logic clear_rq;
    logic load_q;
    logic shift_en;
    logic sub_en;
    logic last;
    logic busy;
    logic done;

`ifdef DIV_ZERO_DETECT_EN
    logic d_is_zero;
    logic div_zero_hit;
    logic div_by_zero;

    assign d_is_zero     = (d_reg == '0);
    assign bus.DivByZero = div_by_zero;
`endif

    div_control #(
        .WIDTH(WIDTH)
    ) u_control (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (bus.Run),
        .ClearR_LoadD (bus.ClearR_LoadD),
`ifdef DIV_ZERO_DETECT_EN
        .d_is_zero    (d_is_zero),
        .div_zero_hit (div_zero_hit),
        .DivByZero    (div_by_zero),
`endif
        .load_d       (load_d),
        .clear_rq     (clear_rq),
        .load_q       (load_q),
        .shift_en     (shift_en),
        .sub_en       (sub_en),
        .last         (last),
        .Busy         (busy),
        .Done         (done)
    );

    // A negative difference (MSB set) means the trial subtraction is discarded.
    assign diff = r_reg - {1'b0, d_reg};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_reg <= '0;
            q_reg <= '0;
            d_reg <= '0;
        end else begin
            if (load_d) begin
                d_reg <= bus.Din;
            end
            if (clear_rq) begin
                r_reg <= '0;
                q_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
            end else if (div_zero_hit) begin
                r_reg <= {1'b0, bus.Din};
                q_reg <= '1;
`endif
            end else if (load_q) begin
                r_reg <= '0;
                q_reg <= bus.Din;
            end else if (shift_en) begin
                r_reg <= {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end else if (sub_en && !diff[WIDTH]) begin
                r_reg    <= diff;
                q_reg[0] <= 1'b1;
            end
        end
    end

    assign bus.Quotient  = q_reg;
    assign bus.Remainder = r_reg[WIDTH-1:0];
    assign bus.Busy      = busy;
    assign bus.Done      = done;

    // last is consumed inside the controller; it is exposed for debug taps.
    logic unused_last;
    assign unused_last = last;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider.
// Expectations for DIV_ZERO_DETECT_EN builds are selected with the same macro.
module tb_restoring_divider;
    import div_pkg::*;

    localparam int WIDTH = 8;
`ifdef DIV_ZERO_DETECT_EN
    localparam int ZERO_LATENCY = 1;
`else
    localparam int ZERO_LATENCY = 2 * WIDTH + 1;
`endif

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    restoring_divider #(
        .WIDTH(WIDTH)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_divisor(input logic [WIDTH-1:0] d);
        bus.Din          = d;
        bus.ClearR_LoadD = 1'b1;
        tick();
        tick();
        bus.ClearR_LoadD = 1'b0;
        tick();
    endtask

    // Leaves Run high; cycles counts edges after the one leaving Start, -1 on timeout.
    task automatic run_division(input logic [WIDTH-1:0] dividend, output int cycles);
        bus.Din = dividend;
        bus.Run = 1'b1;
        cycles  = -1;
        tick();
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.Done === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic release_run();
        bus.Run = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++;
        if (dut.u_control.state !== StartState) begin
            mismatched++;
            $display("[TB] FAIL reset_state got %0d want %0d", dut.u_control.state, StartState);
        end
        compared++;
        if ({bus.Busy, bus.Done, bus.Quotient, bus.Remainder} !== 18'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d want all 0",
                     bus.Busy, bus.Done, bus.Quotient, bus.Remainder);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cycles;
        load_divisor(8'd7);
        run_division(8'd100, cycles);
        compared++;
        if (cycles !== 17) begin
            mismatched++;
            $display("[TB] FAIL basic_latency got %0d want 17", cycles);
        end
        compared++;
        if (bus.Quotient !== 8'd14 || bus.Remainder !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL basic_result got q=%0d r=%0d want q=14 r=2", bus.Quotient, bus.Remainder);
        end
        compared++;
        if (bus.Busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_busy_in_halt got %b want 0", bus.Busy);
        end
        release_run();
    endtask

    task automatic test_patterns();
        logic [WIDTH-1:0] tab_d   [3] = '{8'd1,   8'd9, 8'd255};
        logic [WIDTH-1:0] tab_n   [3] = '{8'd255, 8'd5, 8'd255};
        logic [WIDTH-1:0] tab_q   [3] = '{8'd255, 8'd0, 8'd1};
        logic [WIDTH-1:0] tab_r   [3] = '{8'd0,   8'd5, 8'd0};
        int cycles;
        for (int i = 0; i < 3; i++) begin
            load_divisor(tab_d[i]);
            run_division(tab_n[i], cycles);
            compared++;
            if (cycles !== 17 || bus.Quotient !== tab_q[i] || bus.Remainder !== tab_r[i]) begin
                mismatched++;
                $display("[TB] FAIL pattern_%0d got cyc=%0d q=%0d r=%0d want cyc=17 q=%0d r=%0d",
                         i, cycles, bus.Quotient, bus.Remainder, tab_q[i], tab_r[i]);
            end
            release_run();
        end
    endtask

    task automatic test_div_zero();
        int cycles;
        load_divisor(8'd0);
        run_division(8'd77, cycles);
        compared++;
        if (cycles !== ZERO_LATENCY) begin
            mismatched++;
            $display("[TB] FAIL zero_latency got %0d want %0d", cycles, ZERO_LATENCY);
        end
        compared++;
        if (bus.Quotient !== 8'd255 || bus.Remainder !== 8'd77) begin
            mismatched++;
            $display("[TB] FAIL zero_result got q=%0d r=%0d want q=255 r=77", bus.Quotient, bus.Remainder);
        end
`ifdef DIV_ZERO_DETECT_EN
        compared++;
        if (bus.DivByZero !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_flag got %b want 1", bus.DivByZero);
        end
        release_run();
        compared++;
        if (bus.DivByZero !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_flag_clear got %b want 0", bus.DivByZero);
        end
`else
        release_run();
`endif
    endtask

    task automatic test_reset_mid();
        int cycles;
        load_divisor(8'd7);
        bus.Din = 8'd100;
        bus.Run = 1'b1;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.Run = 1'b0;
        compared++;
        if (dut.u_control.state !== StartState || bus.Busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_state got state=%0d busy=%b want state=%0d busy=0",
                     dut.u_control.state, bus.Busy, StartState);
        end
        compared++;
        if (bus.Quotient !== 8'd0 || bus.Remainder !== 8'd0 || dut.d_reg !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_regs got q=%0d r=%0d d=%0d want 0 0 0",
                     bus.Quotient, bus.Remainder, dut.d_reg);
        end
        tick();
        load_divisor(8'd6);
        run_division(8'd200, cycles);
        compared++;
        if (cycles !== 17 || bus.Quotient !== 8'd33 || bus.Remainder !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL midreset_rerun got cyc=%0d q=%0d r=%0d want cyc=17 q=33 r=2",
                     cycles, bus.Quotient, bus.Remainder);
        end
        release_run();
    endtask

    task automatic test_run_hold();
        int cycles;
        int held_ok;
        load_divisor(8'd10);
        run_division(8'd123, cycles);
        held_ok = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Quotient !== 8'd12 || bus.Remainder !== 8'd3)
                held_ok = 0;
        end
        compared++;
        if (held_ok !== 1) begin
            mismatched++;
            $display("[TB] FAIL run_hold got done=%b busy=%b q=%0d r=%0d want done=1 busy=0 q=12 r=3",
                     bus.Done, bus.Busy, bus.Quotient, bus.Remainder);
        end
        release_run();
        compared++;
        if (dut.u_control.state !== StartState || bus.Done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL run_release got state=%0d done=%b want state=%0d done=0",
                     dut.u_control.state, bus.Done, StartState);
        end
    endtask

    task automatic test_clear_while_busy();
        int cycles;
        load_divisor(8'd7);
        bus.Din = 8'd100;
        bus.Run = 1'b1;
        repeat (4) tick();
        bus.Din          = 8'd3;
        bus.ClearR_LoadD = 1'b1;
        repeat (2) tick();
        bus.ClearR_LoadD = 1'b0;
        cycles = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.Done === 1'b1) begin
                cycles = n;
                break;
            end
        end
        compared++;
        if (cycles < 0 || bus.Quotient !== 8'd14 || bus.Remainder !== 8'd2 || dut.d_reg !== 8'd7) begin
            mismatched++;
            $display("[TB] FAIL clear_busy got cyc=%0d q=%0d r=%0d d=%0d want q=14 r=2 d=7",
                     cycles, bus.Quotient, bus.Remainder, dut.d_reg);
        end
        release_run();
    endtask

    task automatic test_run_and_load();
        int cycles;
        load_divisor(8'd9);
        bus.ClearR_LoadD = 1'b1;
        run_division(8'd50, cycles);
        bus.ClearR_LoadD = 1'b0;
        compared++;
        if (cycles !== 17 || bus.Quotient !== 8'd5 || bus.Remainder !== 8'd5 || dut.d_reg !== 8'd9) begin
            mismatched++;
            $display("[TB] FAIL run_and_load got cyc=%0d q=%0d r=%0d d=%0d want cyc=17 q=5 r=5 d=9",
                     cycles, bus.Quotient, bus.Remainder, dut.d_reg);
        end
        release_run();
    endtask

    initial begin
        compared         = 0;
        mismatched       = 0;
        reset            = 1'b1;
        bus.Run          = 1'b0;
        bus.ClearR_LoadD = 1'b0;
        bus.Din          = '0;
        $display("[TB] restoring_divider bench start");
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_reset_mid();
        test_run_hold();
        test_clear_while_busy();
        test_run_and_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
